// File: rtl/seqmul_pkg.sv
// seqmul_pkg
// Shared types and width helpers for the sequential sign-magnitude multiplier.
//   - state_t   : controller states IDLE / RUN / DONE
//   - magWidth  : magnitude width M = WIDTH-1
//   - resWidth  : result width 2*M+1 (sign + 2M-bit magnitude)
//   - cntWidth  : step counter width, wide enough to hold 0..M
package seqmul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int magWidth(input int width);
      return width - 1;
   endfunction

   function automatic int resWidth(input int width);
      return 2 * (width - 1) + 1;
   endfunction

   // Counter must reach M, i.e. hold M+1 distinct values (M+1 == width)
   function automatic int cntWidth(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/seqmul_sm_dp.sv
// seqmul_sm_dp
// Shift-add magnitude datapath: multiplicand register, multiplier shift
// register, 2M-bit accumulator and step counter.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   load_i         : latch operand magnitudes, clear accumulator and counter
//   step_i         : perform one shift-add step (or the final aligned step)
//   aMag_i, bMag_i : operand magnitudes (M bits)
//   accNext_o      : accumulator value that will be registered at this edge
//   lastStep_o     : the step taken this cycle completes the product
// Parameter EARLY_TERM enables finishing as soon as the remaining multiplier
// bits are all zero; the accumulator is then shifted into final alignment.
import seqmul_pkg::*;

module seqmul_sm_dp #(
   parameter int WIDTH      = 3,
   parameter bit EARLY_TERM = 1'b0
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               load_i,
   input  logic                               step_i,
   input  logic [magWidth(WIDTH)-1:0]         aMag_i,
   input  logic [magWidth(WIDTH)-1:0]         bMag_i,
   output logic [2*magWidth(WIDTH)-1:0]       accNext_o,
   output logic                               lastStep_o
);

   localparam int M  = magWidth(WIDTH);
   localparam int CW = cntWidth(WIDTH);

   logic [M-1:0]   mcand_q, mcand_d;
   logic [M-1:0]   mplier_q, mplier_d;
   logic [2*M-1:0] acc_q, acc_d;
   logic [CW-1:0]  count_q, count_d;

   logic [M:0]     sum;
   logic [2*M:0]   wide;
   logic [2*M-1:0] shifted;
   logic           restZero;
   logic [CW-1:0]  shamt;

   // One shift-add step: the multiplier LSB selects whether the multiplicand
   // is added into the accumulator high half; the carry and the sum are then
   // shifted right together with the low half.  When early termination fires
   // the untouched remaining steps would only shift, so they are collapsed
   // into one right shift by the number of steps still outstanding.
   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      count_d  = count_q;

      sum      = {1'b0, acc_q[2*M-1:M]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
      wide     = {sum, acc_q[M-1:0]};
      shifted  = wide[2*M:1];
      restZero = ((mplier_q >> 1) == '0);

      shamt = '0;
      if (EARLY_TERM && restZero) begin
         shamt = CW'(M - 1) - count_q;
      end

      lastStep_o = (count_q == CW'(M - 1)) || (EARLY_TERM && restZero);

      if (load_i) begin
         mcand_d  = aMag_i;
         mplier_d = bMag_i;
         acc_d    = '0;
         count_d  = '0;
      end else if (step_i) begin
         acc_d    = shifted >> shamt;
         mplier_d = mplier_q >> 1;
         count_d  = count_q + CW'(1);
      end

      accNext_o = acc_d;
   end

   // Datapath registers, cleared by reset so an aborted product never leaks
   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         count_q  <= '0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/seqmul_sm.sv
// seqmul_sm
// Sequential sign-magnitude multiplier with valid/ready handshakes on the
// operand and result sides.  One multiplier bit is consumed per clock.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (accepted only in IDLE)
//   a, b                : WIDTH-bit sign-magnitude operands
//   out_valid/out_ready : result handshake (result held while in DONE)
//   r                   : product, r[2M] sign, r[2M-1:0] magnitude
//   sf, zf              : sign flag (== r[2M]) and zero flag (r == 0)
//   busy                : high in RUN or DONE
// Build option: define SEQMUL_EARLY_TERM_EN to finish as soon as the
// remaining multiplier bits are zero (latency 2..M+1 edges instead of M+1).
import seqmul_pkg::*;

module seqmul_sm #(
   parameter int WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      a,
   input  logic [WIDTH-1:0]      b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [2*WIDTH-2:0]    r,
   output logic                  sf,
   output logic                  zf,
   output logic                  busy
);

   localparam int M  = magWidth(WIDTH);
   localparam int RW = resWidth(WIDTH);

`ifdef SEQMUL_EARLY_TERM_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   state_t         state_q, state_d;
   logic           sign_q, sign_d;
   logic [RW-1:0]  r_q, r_d;
   logic           sf_q, sf_d;
   logic           zf_q, zf_d;

   logic           load;
   logic           step;
   logic [2*M-1:0] accNext;
   logic           lastStep;
   logic           magNonZero;

   seqmul_sm_dp #(
      .WIDTH      (WIDTH),
      .EARLY_TERM (EARLY)
   ) u_dp (
      .clk        (clk),
      .rst        (rst),
      .load_i     (load),
      .step_i     (step),
      .aMag_i     (a[WIDTH-2:0]),
      .bMag_i     (b[WIDTH-2:0]),
      .accNext_o  (accNext),
      .lastStep_o (lastStep)
   );

   assign magNonZero = |accNext;

   // Controller: accept in IDLE, step in RUN, hold the result in DONE.
   // The result registers are loaded from the datapath's next accumulator on
   // the final RUN edge, so they change only when DONE is entered and keep
   // their value afterwards.  A zero magnitude forces a positive sign so
   // negative zero is never produced.
   always_comb begin
      state_d = state_q;
      sign_d  = sign_q;
      r_d     = r_q;
      sf_d    = sf_q;
      zf_d    = zf_q;
      load    = 1'b0;
      step    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               load    = 1'b1;
               sign_d  = a[WIDTH-1] ^ b[WIDTH-1];
               state_d = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (lastStep) begin
               r_d     = {sign_q & magNonZero, accNext};
               sf_d    = sign_q & magNonZero;
               zf_d    = ~magNonZero;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sign_q  <= 1'b0;
         r_q     <= '0;
         sf_q    <= 1'b0;
         zf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sign_q  <= sign_d;
         r_q     <= r_d;
         sf_q    <= sf_d;
         zf_q    <= zf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign r         = r_q;
   assign sf        = sf_q;
   assign zf        = zf_q;

endmodule

// File: tb/tb_seqmul_sm.sv
// tb_seqmul_sm
// Testbench for seqmul_sm with a WIDTH=3 and a WIDTH=8 instance sharing one
// clock.  Expected results come from a behavioural model and go through a
// scoreboard queue per instance.  Follows SEQMUL_EARLY_TERM_EN for latency.
module tb_seqmul_sm;

   typedef struct {
      logic [14:0] r;
      logic        sf;
      logic        zf;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;

   logic        iv3, ir3, ov3, or3, sf3, zf3, busy3;
   logic [2:0]  a3, b3;
   logic [4:0]  r3;

   logic        iv8, ir8, ov8, or8, sf8, zf8, busy8;
   logic [7:0]  a8, b8;
   logic [14:0] r8;

   exp_t sb3[$];
   exp_t sb8[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   seqmul_sm #(.WIDTH(3)) dut3 (
      .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .a(a3), .b(b3),
      .out_valid(ov3), .out_ready(or3), .r(r3), .sf(sf3), .zf(zf3), .busy(busy3)
   );

   seqmul_sm #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
      .out_valid(ov8), .out_ready(or8), .r(r8), .sf(sf8), .zf(zf8), .busy(busy8)
   );

   // Behavioural reference: exact product, sign cleared on zero magnitude,
   // latency counted in edges after the accept edge until out_valid is seen
   function automatic exp_t model(input int w, input logic [7:0] av, input logic [7:0] bv);
      exp_t e;
      int   m, magA, magB, prod, bl;
      logic sgn;
      m    = w - 1;
      magA = int'(av) & ((1 << m) - 1);
      magB = int'(bv) & ((1 << m) - 1);
      sgn  = av[w-1] ^ bv[w-1];
      prod = magA * magB;
      e.zf = (prod == 0);
      e.sf = sgn && (prod != 0);
      e.r  = 15'(prod);
      if (e.sf) e.r = e.r | (15'(1) << (2 * m));
      bl = 0;
      for (int i = 0; i < m; i++) if ((magB >> i) != 0) bl = i + 1;
`ifdef SEQMUL_EARLY_TERM_EN
      e.lat = (bl == 0) ? 1 : bl;
`else
      e.lat = m;
`endif
      return e;
   endfunction

   task automatic op3(input logic [2:0] av, input logic [2:0] bv);
      exp_t e;
      int   n;
      checks++;
      if (ir3 !== 1'b1) begin failures++; $display("FAIL op3_in_ready got=%b want=1", ir3); end
      sb3.push_back(model(3, {5'b0, av}, {5'b0, bv}));
      a3 = av; b3 = bv; iv3 = 1'b1; or3 = 1'b1;
      @(posedge clk); #1;
      iv3 = 1'b0;
      n = 0;
      while (ov3 !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      e = sb3.pop_front();
      checks++;
      if (n !== e.lat) begin failures++; $display("FAIL op3_latency a=%b b=%b got=%0d want=%0d", av, bv, n, e.lat); end
      checks++;
      if ({r3, sf3, zf3} !== {e.r[4:0], e.sf, e.zf}) begin
         failures++;
         $display("FAIL op3_result a=%b b=%b got r=%b sf=%b zf=%b want r=%b sf=%b zf=%b",
                  av, bv, r3, sf3, zf3, e.r[4:0], e.sf, e.zf);
      end
      @(posedge clk); #1;
      checks++;
      if (ov3 !== 1'b0 || ir3 !== 1'b1) begin
         failures++; $display("FAIL op3_return_idle got ov=%b ir=%b want ov=0 ir=1", ov3, ir3);
      end
   endtask

   // hold > 0: keep out_ready low that many cycles in DONE while offering
   // new operands, which must be ignored
   task automatic op8(input logic [7:0] av, input logic [7:0] bv, input int hold);
      exp_t e;
      int   n;
      checks++;
      if (ir8 !== 1'b1) begin failures++; $display("FAIL op8_in_ready got=%b want=1", ir8); end
      sb8.push_back(model(8, av, bv));
      a8 = av; b8 = bv; iv8 = 1'b1; or8 = (hold == 0);
      @(posedge clk); #1;
      iv8 = 1'b0;
      checks++;
      if (busy8 !== 1'b1 || ir8 !== 1'b0) begin
         failures++; $display("FAIL op8_busy got busy=%b ir=%b want busy=1 ir=0", busy8, ir8);
      end
      n = 0;
      while (ov8 !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      e = sb8.pop_front();
      checks++;
      if (n !== e.lat) begin failures++; $display("FAIL op8_latency a=%h b=%h got=%0d want=%0d", av, bv, n, e.lat); end
      for (int i = 0; i < hold; i++) begin
         a8 = 8'($urandom); b8 = 8'($urandom); iv8 = 1'b1;
         @(posedge clk); #1;
         checks++;
         if (ov8 !== 1'b1 || ir8 !== 1'b0 || {r8, sf8, zf8} !== {e.r, e.sf, e.zf}) begin
            failures++;
            $display("FAIL backpressure_hold cyc=%0d got ov=%b ir=%b r=%h want ov=1 ir=0 r=%h",
                     i, ov8, ir8, r8, e.r);
         end
      end
      iv8 = 1'b0; or8 = 1'b1;
      checks++;
      if ({r8, sf8, zf8} !== {e.r, e.sf, e.zf}) begin
         failures++;
         $display("FAIL op8_result a=%h b=%h got r=%h sf=%b zf=%b want r=%h sf=%b zf=%b",
                  av, bv, r8, sf8, zf8, e.r, e.sf, e.zf);
      end
      @(posedge clk); #1;
      checks++;
      if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
         failures++; $display("FAIL op8_return_idle got ov=%b ir=%b want ov=0 ir=1", ov8, ir8);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      iv3 = 1'b0; or3 = 1'b0; a3 = '0; b3 = '0;
      iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if ({ir3, ov3, busy3, r3, sf3, zf3} !== {1'b1, 1'b0, 1'b0, 5'b0, 1'b0, 1'b0}) begin
         failures++; $display("FAIL reset_w3 got ir=%b ov=%b busy=%b r=%b", ir3, ov3, busy3, r3);
      end
      checks++;
      if ({ir8, ov8, busy8, r8, sf8, zf8} !== {1'b1, 1'b0, 1'b0, 15'b0, 1'b0, 1'b0}) begin
         failures++; $display("FAIL reset_w8 got ir=%b ov=%b busy=%b r=%h", ir8, ov8, busy8, r8);
      end
   endtask

   task automatic test_width3();
      op3(3'b011, 3'b110);
      op3(3'b100, 3'b011);
      op3(3'b111, 3'b111);
      op3(3'b101, 3'b000);
   endtask

   task automatic test_width8();
      op8(8'h7F, 8'hFF, 0);
      op8(8'h80, 8'h80, 0);
      op8(8'hFF, 8'hFF, 0);
      op8(8'h00, 8'h80, 0);
   endtask

   task automatic test_early_term();
      op8(8'h05, 8'h01, 0);
      op8(8'h83, 8'h00, 0);
      op8(8'h11, 8'h8C, 0);
   endtask

   task automatic test_backpressure();
      op8(8'h9A, 8'h37, 5);
      op8(8'h22, 8'h03, 0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 12; i++) op8(8'($urandom), 8'($urandom), (i % 3 == 0) ? 2 : 0);
   endtask

   task automatic test_reset_midrun();
      int seen;
      a8 = 8'h7F; b8 = 8'h7F; iv8 = 1'b1; or8 = 1'b1;
      @(posedge clk); #1;
      iv8 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (ov8 !== 1'b0 || ir8 !== 1'b1 || r8 !== 15'h0 || busy8 !== 1'b0) begin
         failures++;
         $display("FAIL reset_midrun got ov=%b ir=%b busy=%b r=%h want ov=0 ir=1 busy=0 r=0",
                  ov8, ir8, busy8, r8);
      end
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (ov8 === 1'b1) seen++;
      end
      checks++;
      if (seen !== 0) begin failures++; $display("FAIL reset_no_result got=%0d want=0", seen); end
   endtask

   initial begin
      test_reset();
      test_width3();
      test_width8();
      test_early_term();
      test_backpressure();
      test_random();
      test_reset_midrun();
      op8(8'hC3, 8'h05, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seqmul_sm.md
Name: seqmul_sm

Overview:
Parametrised sequential sign-magnitude multiplier for the ALU.
- Operands are WIDTH-bit sign-magnitude: MSB is the sign, remaining bits are the magnitude.
- Magnitudes are multiplied by shift-add, one multiplier bit per clock, behind valid/ready handshakes on both input and output.
- Produces a sign-magnitude product plus SF and ZF flags.
- Replaces the fixed 3-bit combinational multiply slice in the ALU datapath.

Parameters:
WIDTH, 3, total operand width including sign bit; magnitude width M = WIDTH-1; WIDTH >= 2.

Ports:
clk  in  1  single clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operands a/b are valid
in_ready  out  1  block can accept operands
a  in  WIDTH  operand A, sign-magnitude
b  in  WIDTH  operand B, sign-magnitude
out_valid  out  1  result r/sf/zf valid
out_ready  in  1  consumer accepts result
r  out  2*M+1  product: r[2M] = sign, r[2M-1:0] = magnitude
sf  out  1  sign flag, equal to r[2M]
zf  out  1  high when the product magnitude is zero
busy  out  1  high in RUN or DONE

Behaviour:
- Reset is synchronous and active-high on rst, with one clock clk.
  - Reset forces state IDLE: in_ready=1, out_valid=0, busy=0.
  - r, sf, zf all reset to 0; internal accumulator and counter are cleared.
  - Reset during RUN or DONE aborts the operation; the partial result is discarded, never presented.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - Accept occurs on in_valid && in_ready at edge T: latch |a|, |b|, sign = a[WIDTH-1]^b[WIDTH-1]; clear accumulator; count=0; go to RUN.
- RUN:
  - in_ready=0; in_valid is ignored.
  - Each cycle: if the multiplier LSB is 1, add the multiplicand to the accumulator high part; shift right (multiplier out, carry into accumulator); count++.
  - After M RUN cycles, go to DONE.
  - out_valid first high in the cycle after edge T+M (latency M+1 edges from accept).
- DONE:
  - out_valid=1. r, sf and zf are held stable until out_ready is sampled high.
  - On out_valid && out_ready, go to IDLE.
  - The next accept is possible no earlier than the following edge; there is no same-cycle accept in DONE.
- Arithmetic:
  - Magnitude is exact, 2M bits; no overflow is possible.
  - Negative zero is normalised: if the magnitude is 0, the sign bit is forced to 0.
  - zf=1 iff r==0; sf=r[2M].
  - Operands of -0 are treated as 0.
- out_ready held high in IDLE/RUN has no effect.
- r, sf and zf outside DONE hold their last presented value (0 after reset). They are valid only while out_valid=1.

Optional Feature:
SEQMUL_EARLY_TERM_EN
- Defined: in RUN, if the remaining unshifted multiplier bits are all zero, the accumulator is aligned (shifted by the remaining count) and the FSM goes to DONE at the next edge.
  - Latency ranges from 2 to M+1 edges.
  - For |b|==0, out_valid rises the cycle after edge T+1.
- Not defined: latency is fixed at M+1 edges for all operands.
- Result values are identical in both builds.

Decomposition:
- Package seqmul_pkg holds:
  - the state enumeration (IDLE/RUN/DONE);
  - the function computing the magnitude width (WIDTH-1);
  - the function computing the result width (2*(WIDTH-1)+1);
  - the counter width (clog2 of M+1).
- One sub-module is natural: seqmul_sm_dp, the accumulator/shift/add datapath with load/step controls.
- The FSM, handshake and flag/sign normalisation stay in seqmul_sm.

Test Plan:
1. WIDTH=3, a=3'b011 (+3), b=3'b110 (-2), out_ready=1 -> r=5'b10110, sf=1, zf=0; out_valid rises after 3 edges from accept (2 without early-term counting as max).
2. WIDTH=3, a=3'b100 (-0), b=3'b011 (+3) -> r=5'b00000, sf=0, zf=1 (no negative zero).
3. WIDTH=8, a=8'h7F (+127), b=8'hFF (-127) -> r=15'h7F01, sf=1, zf=0; latency 8 edges without SEQMUL_EARLY_TERM_EN.
4. Backpressure: result ready, out_ready=0 for 5 cycles with in_valid=1 and new a/b -> r/sf/zf stable, out_valid=1, in_ready=0; out_ready=1 -> IDLE, then the next operands are accepted.
5. Reset mid-RUN: WIDTH=8, rst pulsed 3 cycles after accept -> out_valid=0, in_ready=1, r=0 next cycle; no result is ever presented.
6. With SEQMUL_EARLY_TERM_EN, WIDTH=8, a=8'h05, b=8'h01 -> r=15'h0005, out_valid rises 2 edges after accept; without the macro, 8 edges.
